spi_master_tx: RTL and testbench
================================

# spi_master_tx

Transmit shift engine of the SPI master: takes 32-bit words from the TX FIFO and shifts them out MSB-first on `sdo0` in standard mode, or 4 bits per edge on `sdo3..sdo0` in quad mode. It sits beside the receive shifter and is driven by the same clock-generator edge strobe and the same bit-count programming from the controller FSM. It gates the SPI clock while waiting for FIFO data and pulses `tx_done` on the final edge of a transfer.

## Interface
- No parameters.
- `clk`  in  1  system clock
- `rstn`  in  1  asynchronous, active-low reset
- `en`  in  1  start request; sampled only in IDLE
- `tx_edge`  in  1  one-`clk` strobe marking an SPI clock edge on which output data advances
- `tx_done`  out  1  one-cycle pulse on the final `tx_edge` of a transfer
- `sdo0`..`sdo3`  out  1 each  serial data out; `sdo1..3` are used only in quad mode
- `en_quad_in`  in  1  1 = quad mode (4 bits per edge), 0 = standard mode (1 bit per edge)
- `counter_in`  in  16  transfer length in bits
- `counter_in_upd`  in  1  load `counter_in` into the edge target
- `data`  in  32  word from the TX FIFO
- `data_valid`  in  1  FIFO has a word
- `data_ready`  out  1  word is accepted; transfer when `data_valid & data_ready`
- `clk_en_o`  out  1  SPI clock enable to the clock generator

## Operation
- Registers:
  - `data_int[31:0]` holds the shift data.
  - `counter[15:0]` counts edges.
  - `counter_trgt[15:0]` holds the edge target.
  - `state` is one of IDLE, TRANSMIT, WAIT_DATA.
  - `clk_en_o` is registered.
- Target: `counter_in_upd` in IDLE loads `counter_trgt` with `{2'b00, counter_in[15:2]}` if `en_quad_in`, else `counter_in`.
  - Quad lengths are truncated to a multiple of 4.
  - `counter_in_upd` outside IDLE is ignored.
- Outputs:
  - Standard mode: `sdo0 = data_int[31]`; `sdo1..3` are 0.
  - Quad mode: `{sdo3,sdo2,sdo1,sdo0} = data_int[31:28]`.
- IDLE:
  - `data_ready = en & (next target != 0)`. "Next target" includes a same-cycle `counter_in_upd`.
  - On a transfer: load `data_int <= data`, set `counter <= 0`, set `clk_en_o <= 1`, go to TRANSMIT.
  - If `en` is high but the target is 0: stay in IDLE and never assert `data_ready`.
- TRANSMIT, on `tx_edge`:
  - Last edge (`counter == counter_trgt-1`):
    - `tx_done = 1` (combinational, same cycle).
    - `counter <= 0`, `clk_en_o <= 0`, go to IDLE.
    - `data_int` is held, so the last bits stay on `sdo*`.
  - Word boundary, not last (`counter[4:0]==31` in standard mode, `counter[2:0]==7` in quad mode):
    - `counter <= counter+1`.
    - `data_ready = 1` combinationally.
    - If `data_valid`: `data_int <= data`, stay in TRANSMIT.
    - Otherwise: `clk_en_o <= 0`, go to WAIT_DATA.
  - Otherwise: `counter <= counter+1`; shift `data_int` left by 1 (standard) or by 4 (quad), zero-filled.
- TRANSMIT without `tx_edge`: all registers hold.
- WAIT_DATA:
  - `data_ready = 1`.
  - On `data_valid`: `data_int <= data`, `clk_en_o <= 1`, go to TRANSMIT.
  - `tx_edge` is ignored.
- `en` is not sampled outside IDLE. Deasserting `en` mid-transfer has no effect.
- `data_ready` is 0 in every case not listed above.
- `counter` never wraps: the last-edge check precedes increment, and the target is at least 1.

## Timing
- Reset values:
  - State IDLE; `counter=0`; `counter_trgt=8`; `data_int=0`.
  - `clk_en_o=0`; `sdo0..3=0`; `tx_done=0`; `data_ready=0`.
- Reset is asynchronous. Reset asserted mid-transfer aborts immediately to reset values. The next transfer requires a fresh `en`.
- Load to first bit:
  - The first bit(s) appear on `sdo*` the `clk` cycle after the accepting handshake, before the first `tx_edge`.
  - Each `tx_edge` advances `sdo*` in the following cycle.
- An N-edge transfer consumes exactly N `tx_edge` strobes in TRANSMIT.
  - Words consumed: `ceil(N/32)` in standard mode, `ceil(N/8)` in quad mode.
- WAIT_DATA exit: `clk_en_o` rises 1 cycle after `data_valid` is accepted.
- `en` and `data_valid` both high in IDLE: handshake in that cycle, TRANSMIT the next cycle.
- Back-to-back transfers: `en` held high through the `tx_done` cycle starts the next transfer on the first IDLE cycle.

## Test plan
- Standard mode, 8 bits:
  - Stimulus: `counter_in=8` with upd, `en=1`, `data=0xA5000000`, 8 `tx_edge` strobes.
  - Required: `sdo0` sequence 1,0,1,0,0,1,0,1; `tx_done` on the 8th edge; one FIFO handshake; `clk_en_o` back to 0.
- Quad mode, 32 bits:
  - Stimulus: `counter_in=32` with upd, `en_quad_in=1`, `data=0x12345678`.
  - Required: `{sdo3..0}` = 1,2,3,4,5,6,7,8 over 8 edges; `tx_done` on edge 8; `sdo1..3` toggle.
- Standard mode, 64 bits with FIFO stall:
  - Stimulus: second word `0xFFFFFFFF` withheld for 5 cycles after edge 32.
  - Required: WAIT_DATA entered; `clk_en_o=0`; `data_ready=1` held; stray `tx_edge` ignored; resume with all ones; exactly two handshakes; `tx_done` on edge 64.
- Zero and truncated lengths:
  - Stimulus: `counter_in=0`, `en=1`. Then quad mode with `counter_in=3`.
  - Required: `data_ready` stays 0 and state stays IDLE in both cases. Then quad with `counter_in=10`: target 2, `tx_done` on edge 2.
- Reset mid-transfer:
  - Stimulus: `rstn` low after edge 5 of a 32-bit transfer.
  - Required: all outputs 0 asynchronously; `counter_trgt=8` after release; the next 8-bit transfer behaves as in the first scenario.
- Ignored controls mid-transfer:
  - Stimulus: during TRANSMIT, drive `counter_in_upd` with `counter_in=4` and deassert `en`.
  - Required: the transfer completes at its original length.

Source files
------------

// File: rtl/spi_master_tx.sv
// SPI master transmit shifter: streams 32-bit FIFO words out MSB-first on sdo0,
// or a nibble per edge on sdo3..sdo0 in quad mode, pausing the SPI clock on FIFO underrun.
module spi_master_tx (
    input  logic        clk,
    input  logic        rstn,
    input  logic        en,
    input  logic        tx_edge,
    output logic        tx_done,
    output logic        sdo0,
    output logic        sdo1,
    output logic        sdo2,
    output logic        sdo3,
    input  logic        en_quad_in,
    input  logic [15:0] counter_in,
    input  logic        counter_in_upd,
    input  logic [31:0] data,
    input  logic        data_valid,
    output logic        data_ready,
    output logic        clk_en_o
);

    typedef enum logic [1:0] {IDLE, TRANSMIT, WAIT_DATA} state_t;

    state_t      state_q;
    logic [31:0] data_int_q;
    logic [15:0] counter_q;
    logic [15:0] counter_trgt_q;
    logic [15:0] counter_trgt_d;
    logic        clk_en_q;
    logic        last_edge;
    logic        word_end;

    always_comb begin
        counter_trgt_d = counter_trgt_q;
        if (state_q == IDLE && counter_in_upd)
            counter_trgt_d = en_quad_in ? {2'b00, counter_in[15:2]} : counter_in;

        last_edge = (counter_q == counter_trgt_q - 16'd1);
        word_end  = en_quad_in ? (counter_q[2:0] == 3'd7) : (counter_q[4:0] == 5'd31);
        tx_done   = (state_q == TRANSMIT) && tx_edge && last_edge;

        data_ready = 1'b0;
        case (state_q)
            IDLE:      data_ready = en && (counter_trgt_d != 16'd0);
            TRANSMIT:  data_ready = tx_edge && !last_edge && word_end;
            WAIT_DATA: data_ready = 1'b1;
            default:   data_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q        <= IDLE;
            data_int_q     <= 32'd0;
            counter_q      <= 16'd0;
            counter_trgt_q <= 16'd8;
            clk_en_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    counter_trgt_q <= counter_trgt_d;
                    if (data_ready && data_valid) begin
                        data_int_q <= data;
                        counter_q  <= 16'd0;
                        clk_en_q   <= 1'b1;
                        state_q    <= TRANSMIT;
                    end
                end
                TRANSMIT: begin
                    if (tx_edge) begin
                        // Last bits are left on the pins after the final edge.
                        if (last_edge) begin
                            counter_q <= 16'd0;
                            clk_en_q  <= 1'b0;
                            state_q   <= IDLE;
                        end else begin
                            counter_q <= counter_q + 16'd1;
                            if (word_end) begin
                                if (data_valid) begin
                                    data_int_q <= data;
                                end else begin
                                    clk_en_q <= 1'b0;
                                    state_q  <= WAIT_DATA;
                                end
                            end else if (en_quad_in) begin
                                data_int_q <= {data_int_q[27:0], 4'b0000};
                            end else begin
                                data_int_q <= {data_int_q[30:0], 1'b0};
                            end
                        end
                    end
                end
                WAIT_DATA: begin
                    if (data_valid) begin
                        data_int_q <= data;
                        clk_en_q   <= 1'b1;
                        state_q    <= TRANSMIT;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign clk_en_o = clk_en_q;
    assign sdo0     = en_quad_in ? data_int_q[28] : data_int_q[31];
    assign sdo1     = en_quad_in & data_int_q[29];
    assign sdo2     = en_quad_in & data_int_q[30];
    assign sdo3     = en_quad_in & data_int_q[31];

endmodule

// File: tb/tb_spi_master_tx.sv
// Directed bench for spi_master_tx: standard, quad, FIFO stall, zero/truncated
// lengths, asynchronous reset and ignored mid-transfer controls.
module tb_spi_master_tx;

    logic        clk = 1'b0;
    logic        rstn;
    logic        en;
    logic        tx_edge;
    logic        tx_done;
    logic        sdo0, sdo1, sdo2, sdo3;
    logic        en_quad_in;
    logic [15:0] counter_in;
    logic        counter_in_upd;
    logic [31:0] data;
    logic        data_valid;
    logic        data_ready;
    logic        clk_en_o;

    int vectors     = 0;
    int miscompares = 0;
    int hs_cnt      = 0;
    int hs_base;
    logic [31:0] w;

    spi_master_tx dut (
        .clk            (clk),
        .rstn           (rstn),
        .en             (en),
        .tx_edge        (tx_edge),
        .tx_done        (tx_done),
        .sdo0           (sdo0),
        .sdo1           (sdo1),
        .sdo2           (sdo2),
        .sdo3           (sdo3),
        .en_quad_in     (en_quad_in),
        .counter_in     (counter_in),
        .counter_in_upd (counter_in_upd),
        .data           (data),
        .data_valid     (data_valid),
        .data_ready     (data_ready),
        .clk_en_o       (clk_en_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (rstn && data_valid && data_ready) hs_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic edge_chk(input logic [3:0] exp_sdo, input logic exp_done, input string tag);
        chk({tag, " sdo"}, {28'd0, sdo3, sdo2, sdo1, sdo0}, {28'd0, exp_sdo});
        tx_edge = 1'b1;
        #1;
        chk({tag, " done"}, {31'd0, tx_done}, {31'd0, exp_done});
        step();
        tx_edge = 1'b0;
    endtask

    task automatic start(input logic [15:0] len, input logic upd, input logic quad,
                         input logic [31:0] word, input string tag);
        counter_in     = len;
        counter_in_upd = upd;
        en_quad_in     = quad;
        en             = 1'b1;
        data           = word;
        data_valid     = 1'b1;
        #1;
        chk({tag, " ready"}, {31'd0, data_ready}, 32'd1);
        step();
        counter_in_upd = 1'b0;
        data_valid     = 1'b0;
        en             = 1'b0;
        chk({tag, " clk_en on"}, {31'd0, clk_en_o}, 32'd1);
    endtask

    initial begin
        rstn = 1'b0; en = 1'b0; tx_edge = 1'b0; en_quad_in = 1'b0;
        counter_in = 16'd0; counter_in_upd = 1'b0; data = 32'd0; data_valid = 1'b0;
        step(); step();
        chk("rst sdo", {28'd0, sdo3, sdo2, sdo1, sdo0}, 32'd0);
        chk("rst clk_en", {31'd0, clk_en_o}, 32'd0);
        chk("rst done", {31'd0, tx_done}, 32'd0);
        chk("rst ready", {31'd0, data_ready}, 32'd0);
        rstn = 1'b1;
        step();

        // Standard mode, 8 bits
        hs_base = hs_cnt;
        w = 32'hA500_0000;
        start(16'd8, 1'b1, 1'b0, w, "std8");
        for (int i = 0; i < 8; i++)
            edge_chk({3'b000, w[31-i]}, (i == 7), $sformatf("std8 e%0d", i));
        chk("std8 clk_en off", {31'd0, clk_en_o}, 32'd0);
        chk("std8 sdo held", {31'd0, sdo0}, 32'd1);
        chk("std8 handshakes", hs_cnt - hs_base, 32'd1);
        step();

        // Quad mode, 32 bits
        w = 32'h1234_5678;
        start(16'd32, 1'b1, 1'b1, w, "quad32");
        for (int i = 0; i < 8; i++)
            edge_chk(4'(i + 1), (i == 7), $sformatf("quad32 e%0d", i));
        chk("quad32 clk_en off", {31'd0, clk_en_o}, 32'd0);
        step();

        // Standard mode, 64 bits with FIFO stall after the first word
        hs_base = hs_cnt;
        w = 32'hC3A5_0F01;
        start(16'd64, 1'b1, 1'b0, w, "std64");
        for (int i = 0; i < 31; i++)
            edge_chk({3'b000, w[31-i]}, 1'b0, $sformatf("std64 e%0d", i));
        chk("std64 e31 sdo", {31'd0, sdo0}, {31'd0, w[0]});
        tx_edge = 1'b1;
        #1;
        chk("std64 e31 ready", {31'd0, data_ready}, 32'd1);
        chk("std64 e31 done", {31'd0, tx_done}, 32'd0);
        step();
        tx_edge = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("stall%0d clk_en", c), {31'd0, clk_en_o}, 32'd0);
            chk($sformatf("stall%0d ready", c), {31'd0, data_ready}, 32'd1);
            chk($sformatf("stall%0d sdo", c), {31'd0, sdo0}, {31'd0, w[0]});
            tx_edge = (c == 2);
            step();
            tx_edge = 1'b0;
        end
        data = 32'hFFFF_FFFF;
        data_valid = 1'b1;
        #1;
        chk("resume ready", {31'd0, data_ready}, 32'd1);
        step();
        data_valid = 1'b0;
        chk("resume clk_en", {31'd0, clk_en_o}, 32'd1);
        for (int i = 32; i < 64; i++)
            edge_chk(4'b0001, (i == 63), $sformatf("std64 e%0d", i));
        chk("std64 handshakes", hs_cnt - hs_base, 32'd2);
        chk("std64 clk_en off", {31'd0, clk_en_o}, 32'd0);
        step();

        // Zero and truncated lengths
        hs_base = hs_cnt;
        counter_in = 16'd0; counter_in_upd = 1'b1; en_quad_in = 1'b0;
        en = 1'b1; data = 32'h5555_5555; data_valid = 1'b1;
        #1;
        chk("zero ready", {31'd0, data_ready}, 32'd0);
        step();
        counter_in_upd = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("zero%0d ready", c), {31'd0, data_ready}, 32'd0);
            chk($sformatf("zero%0d clk_en", c), {31'd0, clk_en_o}, 32'd0);
            step();
        end
        counter_in = 16'd3; counter_in_upd = 1'b1; en_quad_in = 1'b1;
        #1;
        chk("q3 ready", {31'd0, data_ready}, 32'd0);
        step();
        counter_in_upd = 1'b0;
        chk("q3 ready held", {31'd0, data_ready}, 32'd0);
        chk("q3 clk_en", {31'd0, clk_en_o}, 32'd0);
        chk("zero handshakes", hs_cnt - hs_base, 32'd0);
        start(16'd10, 1'b1, 1'b1, 32'hABCD_0000, "q10");
        edge_chk(4'hA, 1'b0, "q10 e0");
        edge_chk(4'hB, 1'b1, "q10 e1");
        chk("q10 clk_en off", {31'd0, clk_en_o}, 32'd0);
        step();

        // Reset mid-transfer
        w = 32'hDEAD_BEEF;
        start(16'd32, 1'b1, 1'b0, w, "rst32");
        for (int i = 0; i < 5; i++)
            edge_chk({3'b000, w[31-i]}, 1'b0, $sformatf("rst32 e%0d", i));
        rstn = 1'b0;
        #1;
        chk("arst sdo", {28'd0, sdo3, sdo2, sdo1, sdo0}, 32'd0);
        chk("arst clk_en", {31'd0, clk_en_o}, 32'd0);
        chk("arst done", {31'd0, tx_done}, 32'd0);
        chk("arst ready", {31'd0, data_ready}, 32'd0);
        step();
        rstn = 1'b1;
        step();
        w = 32'hA500_0000;
        start(16'd0, 1'b0, 1'b0, w, "post");
        for (int i = 0; i < 8; i++)
            edge_chk({3'b000, w[31-i]}, (i == 7), $sformatf("post e%0d", i));
        chk("post clk_en off", {31'd0, clk_en_o}, 32'd0);
        step();

        // Length update and en deassertion during TRANSMIT are ignored
        w = 32'h3C5A_0000;
        counter_in = 16'd16; counter_in_upd = 1'b1; en_quad_in = 1'b0;
        en = 1'b1; data = w; data_valid = 1'b1;
        step();
        counter_in_upd = 1'b0; data_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i == 2) begin
                counter_in = 16'd4; counter_in_upd = 1'b1; en = 1'b0;
            end else begin
                counter_in_upd = 1'b0;
            end
            edge_chk({3'b000, w[31-i]}, (i == 15), $sformatf("ign e%0d", i));
        end
        counter_in_upd = 1'b0;
        chk("ign clk_en off", {31'd0, clk_en_o}, 32'd0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
